// File: rtl/tmds_channel_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_channel_encoder
// Brief    : DVI 1.0 TMDS encoder for one colour lane, 3-stage pipeline with
//            running DC-balance tracking.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_channel_encoder #(
  parameter bit INVERT_OUTPUT = 1'b0
) (
  input  logic       pixelClk,
  input  logic       reset,
  input  logic       de,
  input  logic [7:0] data,
  input  logic       c0,
  input  logic       c1,
  output logic [9:0] tmds
);

  localparam logic [9:0] c_CTRL_00   = 10'h354;
  localparam logic [9:0] c_CTRL_01   = 10'h0AB;
  localparam logic [9:0] c_CTRL_10   = 10'h154;
  localparam logic [9:0] c_CTRL_11   = 10'h2AB;
  localparam logic [9:0] c_INV_MASK  = {10{INVERT_OUTPUT}};

  function automatic logic [3:0] f_popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Stage 1: sample inputs and count data ones
  logic       r_s1_de;
  logic [7:0] r_s1_data;
  logic [1:0] r_s1_ctrl;
  logic [3:0] r_s1_n1d;

  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      r_s1_de   <= 1'b0;
      r_s1_data <= 8'h00;
      r_s1_ctrl <= 2'b00;
      r_s1_n1d  <= 4'd0;
    end else begin
      r_s1_de   <= de;
      r_s1_data <= data;
      r_s1_ctrl <= {c1, c0};
      r_s1_n1d  <= f_popcount8(data);
    end
  end

  // Stage 2: transition-minimised word
  logic       w_use_xnor;
  logic [8:0] w_qm;

  always_comb begin
    w_use_xnor = (r_s1_n1d > 4'd4) || ((r_s1_n1d == 4'd4) && !r_s1_data[0]);
    w_qm       = 9'd0;
    w_qm[0]    = r_s1_data[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ r_s1_data[i]) : (w_qm[i-1] ^ r_s1_data[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  logic       r_s2_de;
  logic [1:0] r_s2_ctrl;
  logic [8:0] r_s2_qm;
  logic [3:0] r_s2_n1q;
  logic [3:0] r_s2_n0q;

  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      r_s2_de   <= 1'b0;
      r_s2_ctrl <= 2'b00;
      r_s2_qm   <= 9'd0;
      r_s2_n1q  <= 4'd0;
      r_s2_n0q  <= 4'd8;
    end else begin
      r_s2_de   <= r_s1_de;
      r_s2_ctrl <= r_s1_ctrl;
      r_s2_qm   <= w_qm;
      r_s2_n1q  <= f_popcount8(w_qm[7:0]);
      r_s2_n0q  <= 4'd8 - f_popcount8(w_qm[7:0]);
    end
  end

  // Stage 3: DC balancing; r_cnt equals the running disparity of emitted characters
  logic signed [4:0] r_cnt;
  logic signed [4:0] w_cnt_next;
  logic signed [4:0] w_diff;
  logic        [9:0] w_char;
  logic        [9:0] r_tmds;
  logic              w_q8;

  always_comb begin
    w_q8       = r_s2_qm[8];
    w_diff     = $signed({1'b0, r_s2_n1q}) - $signed({1'b0, r_s2_n0q});
    w_char     = c_CTRL_00;
    w_cnt_next = 5'sd0;
    if (!r_s2_de) begin
      case (r_s2_ctrl)
        2'b00:   w_char = c_CTRL_00;
        2'b01:   w_char = c_CTRL_01;
        2'b10:   w_char = c_CTRL_10;
        default: w_char = c_CTRL_11;
      endcase
    end else if ((r_cnt == 5'sd0) || (r_s2_n1q == r_s2_n0q)) begin
      w_char     = {~w_q8, w_q8, w_q8 ? r_s2_qm[7:0] : ~r_s2_qm[7:0]};
      w_cnt_next = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if (((r_cnt > 5'sd0) && (r_s2_n1q > r_s2_n0q)) ||
                 ((r_cnt < 5'sd0) && (r_s2_n0q > r_s2_n1q))) begin
      w_char     = {1'b1, w_q8, ~r_s2_qm[7:0]};
      w_cnt_next = r_cnt + (w_q8 ? 5'sd2 : 5'sd0) - w_diff;
    end else begin
      w_char     = {1'b0, w_q8, r_s2_qm[7:0]};
      w_cnt_next = r_cnt - (w_q8 ? 5'sd0 : 5'sd2) + w_diff;
    end
  end

  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 5'sd0;
      r_tmds <= c_CTRL_00 ^ c_INV_MASK;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tmds <= w_char ^ c_INV_MASK;
    end
  end

  assign tmds = r_tmds;

endmodule
`default_nettype wire
